// File: rtl/ic_shift_pkg.sv
// ic_shift_pkg: shared direction constants and counter width helper for the shift/latch register
package ic_shift_pkg;
    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction
endpackage

// File: rtl/frame_counter.sv
// frame_counter: counts shifts modulo WIDTH and flags the frame-completing increment
module frame_counter
    import ic_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_wrap
);
    localparam int CW = CNT_W(WIDTH);
    logic [CW-1:0] r_cnt;
    assign o_wrap = i_inc && !i_clr && (r_cnt == CW'(WIDTH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/shift_latch_reg.sv
// shift_latch_reg: parametrised serial-in/parallel-out shift register with storage latch,
// selectable shift direction, optional auto-latch and a frame-done pulse
module shift_latch_reg
    import ic_shift_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit AUTO_LATCH = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SH_EN,
    input  logic             SER,
    input  logic             DIR,
    input  logic             SRCLR,
    input  logic             LATCH,
    input  logic             OE_bar,
    output logic [WIDTH-1:0] Q,
    output logic             QS,
    output logic             FRAME_DONE
);
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_st;
    logic             r_done;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_wrap;
    frame_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (CLK),
        .rst    (RST),
        .i_inc  (SH_EN),
        .i_clr  (!SRCLR),
        .o_wrap (w_wrap)
    );
    assign w_sr_next = (DIR == DIR_LSB) ? {SER, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], SER};
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr   <= '0;
            r_st   <= '0;
            r_done <= 1'b0;
        end else begin
            if (!SRCLR)
                r_sr <= '0;
            else if (SH_EN)
                r_sr <= w_sr_next;
            // auto-latch captures the completed frame, overriding a manual latch of the old value
            if (AUTO_LATCH && w_wrap)
                r_st <= w_sr_next;
            else if (LATCH)
                r_st <= r_sr;
            r_done <= w_wrap;
        end
    end
    assign Q          = OE_bar ? 'z : r_st;
    assign QS         = (DIR == DIR_LSB) ? r_sr[0] : r_sr[WIDTH-1];
    assign FRAME_DONE = r_done;
endmodule

// File: tb/tb_shift_latch_reg.sv
// tb_shift_latch_reg: scoreboard bench comparing a manual-latch and an auto-latch instance
// against an arithmetic reference model
module tb_shift_latch_reg;
    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic       qs;
        logic       done;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0, sh_en = 1'b0, ser = 1'b0, dir = 1'b0;
    logic srclr = 1'b1, latch = 1'b0, oe_bar = 1'b0;
    wire [7:0] q0, q1;
    wire qs0, qs1, done0, done1;

    exp_t sb[$];
    int checks = 0, errors = 0;
    int m_sr = 0, m_st0 = 0, m_st1 = 0, m_shifts = 0;

    always #10 clk = ~clk;

    shift_latch_reg #(.WIDTH(8), .AUTO_LATCH(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .SH_EN(sh_en), .SER(ser), .DIR(dir), .SRCLR(srclr),
        .LATCH(latch), .OE_bar(oe_bar), .Q(q0), .QS(qs0), .FRAME_DONE(done0));
    shift_latch_reg #(.WIDTH(8), .AUTO_LATCH(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .SH_EN(sh_en), .SER(ser), .DIR(dir), .SRCLR(srclr),
        .LATCH(latch), .OE_bar(oe_bar), .Q(q1), .QS(qs1), .FRAME_DONE(done1));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the following rising edge
    task automatic step(input bit r, input bit sh, input bit s, input bit d,
                        input bit clr_n, input bit lat, input bit oe);
        exp_t e;
        int nsr;
        bit wrap;
        @(negedge clk);
        rst = r; sh_en = sh; ser = s; dir = d; srclr = clr_n; latch = lat; oe_bar = oe;
        if (r) begin
            m_sr = 0; m_st0 = 0; m_st1 = 0; m_shifts = 0; wrap = 0;
        end else begin
            wrap = clr_n && sh && ((m_shifts + 1) % 8 == 0);
            nsr = !clr_n ? 0 : !sh ? m_sr : d ? ((m_sr >> 1) | (int'(s) << 7)) : (((m_sr << 1) | int'(s)) & 255);
            if (lat) m_st0 = m_sr;
            if (wrap) m_st1 = nsr;
            else if (lat) m_st1 = m_sr;
            m_shifts = !clr_n ? 0 : sh ? m_shifts + 1 : m_shifts;
            m_sr = nsr;
        end
        e.q0 = oe ? 8'hzz : 8'(m_st0);
        e.q1 = oe ? 8'hzz : 8'(m_st1);
        e.qs = d ? m_sr[0] : m_sr[7];
        e.done = wrap;
        sb.push_back(e);
    endtask

    task automatic shift_byte(input logic [7:0] v, input bit d, input bit oe);
        for (int i = 0; i < 8; i++)
            step(0, 1, d ? v[i] : v[7-i], d, 1, 0, oe);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #5;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q_manual", q0, e.q0);
            check("q_auto", q1, e.q1);
            check("qs_manual", {7'd0, qs0}, {7'd0, e.qs});
            check("qs_auto", {7'd0, qs1}, {7'd0, e.qs});
            check("done_manual", {7'd0, done0}, {7'd0, e.done});
            check("done_auto", {7'd0, done1}, {7'd0, e.done});
        end
    end

    initial begin
        step(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        shift_byte(8'hB2, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        shift_byte(8'h5A, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, i[0], 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        shift_byte(8'hB2, 0, 0);
        step(0, 1, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom),
                 $urandom_range(7) == 0 ? ~dir : dir, $urandom_range(15) != 0,
                 $urandom_range(7) == 0, $urandom_range(3) == 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
